// File: rtl/rc4_phase_sequencer.sv
// RC4 top-level phase sequencer: runs S-init, KSA and PRGA in order, owns the
// single S-RAM write port and aborts any phase that exceeds its watchdog budget.
module rc4_phase_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned DATA_W         = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
   output logic              busy,
   output logic              timeout_error,
   output logic [1:0]        phase,
   output logic              init_start,
   output logic              ksa_start,
   output logic              prga_start,
   input  logic              init_finished,
   input  logic              ksa_finished,
   input  logic              prga_finished,
   input  logic [ADDR_W-1:0] init_address,
   input  logic [ADDR_W-1:0] ksa_address,
   input  logic [ADDR_W-1:0] prga_address,
   input  logic [DATA_W-1:0] init_data,
   input  logic [DATA_W-1:0] ksa_data,
   input  logic [DATA_W-1:0] prga_data,
   input  logic              init_we,
   input  logic              ksa_we,
   input  logic              prga_we,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_GAP1,
      S_KSA,
      S_GAP2,
      S_PRGA,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] wd_count;
   logic        wd_expired;
   logic        next_in_phase;

   always_comb begin
      state_next = state;
      wd_expired = (wd_count == WD_LAST);
      case (state)
         S_IDLE:  if (start) state_next = S_INIT;
         // the active engine's finished beats a same-cycle watchdog expiry
         S_INIT: begin
            if (init_finished)   state_next = S_GAP1;
            else if (wd_expired) state_next = S_ERROR;
         end
         S_GAP1:  state_next = S_KSA;
         S_KSA: begin
            if (ksa_finished)    state_next = S_GAP2;
            else if (wd_expired) state_next = S_ERROR;
         end
         S_GAP2:  state_next = S_PRGA;
         S_PRGA: begin
            if (prga_finished)   state_next = S_DONE;
            else if (wd_expired) state_next = S_ERROR;
         end
         S_DONE:  if (!start) state_next = S_IDLE;
         S_ERROR: if (!start) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign next_in_phase = (state_next == S_INIT) || (state_next == S_KSA) ||
                          (state_next == S_PRGA);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         init_start <= 1'b0;
         ksa_start  <= 1'b0;
         prga_start <= 1'b0;
         wd_count   <= '0;
      end else begin
         state      <= state_next;
         init_start <= (state_next == S_INIT);
         ksa_start  <= (state_next == S_KSA);
         prga_start <= (state_next == S_PRGA);
         // restart on phase entry, hold at zero outside the phases
         if (!next_in_phase || (state_next != state))
            wd_count <= '0;
         else
            wd_count <= wd_count + 16'd1;
      end
   end

   always_comb begin
      mem_address   = '0;
      mem_data      = '0;
      mem_we        = 1'b0;
      phase         = 2'd0;
      done          = 1'b0;
      busy          = 1'b0;
      timeout_error = 1'b0;
      case (state)
         S_INIT: begin
            mem_address = init_address;
            mem_data    = init_data;
            mem_we      = init_we;
            phase       = 2'd1;
            busy        = 1'b1;
         end
         S_KSA: begin
            mem_address = ksa_address;
            mem_data    = ksa_data;
            mem_we      = ksa_we;
            phase       = 2'd2;
            busy        = 1'b1;
         end
         S_PRGA: begin
            mem_address = prga_address;
            mem_data    = prga_data;
            mem_we      = prga_we;
            phase       = 2'd3;
            busy        = 1'b1;
         end
         S_GAP1, S_GAP2: busy = 1'b1;
         S_DONE:         done = 1'b1;
         S_ERROR:        timeout_error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer: engine stubs finish after a set
// number of start-high cycles; all expectations are hand-computed constants.
module tb_rc4_phase_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       done, busy, timeout_error;
   logic [1:0] phase;
   logic       init_start, ksa_start, prga_start;
   logic       init_finished, ksa_finished, prga_finished;
   logic [7:0] mem_address, mem_data;
   logic       mem_we;

   logic init_fin_model = 1'b0, ksa_fin_model = 1'b0, prga_fin_model = 1'b0;
   logic init_fin_force = 1'b0, ksa_fin_force = 1'b0, prga_fin_force = 1'b0;
   int   init_lat = 10, ksa_lat = 12, prga_lat = 5;
   int   icnt = 0, kcnt = 0, pcnt = 0;

   int vectors = 0;
   int miscompares = 0;
   int n;

   assign init_finished = init_fin_model | init_fin_force;
   assign ksa_finished  = ksa_fin_model  | ksa_fin_force;
   assign prga_finished = prga_fin_model | prga_fin_force;

   rc4_phase_sequencer #(
      .TIMEOUT_CYCLES(16),
      .ADDR_W(8),
      .DATA_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .done(done),
      .busy(busy),
      .timeout_error(timeout_error),
      .phase(phase),
      .init_start(init_start),
      .ksa_start(ksa_start),
      .prga_start(prga_start),
      .init_finished(init_finished),
      .ksa_finished(ksa_finished),
      .prga_finished(prga_finished),
      .init_address(8'h11),
      .ksa_address(8'h22),
      .prga_address(8'h33),
      .init_data(8'hA1),
      .ksa_data(8'hB2),
      .prga_data(8'hC3),
      .init_we(1'b1),
      .ksa_we(1'b1),
      .prga_we(1'b1),
      .mem_address(mem_address),
      .mem_data(mem_data),
      .mem_we(mem_we)
   );

   always #5 clk = ~clk;

   // engine stubs: finished asserts in the lat-th cycle of start being high
   always @(negedge clk) begin
      if (init_start === 1'b1) begin
         icnt++;
         init_fin_model = (init_lat != 0) && (icnt == init_lat);
      end else begin
         icnt = 0;
         init_fin_model = 1'b0;
      end
      if (ksa_start === 1'b1) begin
         kcnt++;
         ksa_fin_model = (ksa_lat != 0) && (kcnt == ksa_lat);
      end else begin
         kcnt = 0;
         ksa_fin_model = 1'b0;
      end
      if (prga_start === 1'b1) begin
         pcnt++;
         prga_fin_model = (prga_lat != 0) && (pcnt == prga_lat);
      end else begin
         pcnt = 0;
         prga_fin_model = 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // called just after the edge entering a phase; leaves the bench just after the exit edge
   task automatic phase_run(input string tag, input logic [1:0] ph, input logic [2:0] starts,
                            input logic [7:0] addr, input logic [7:0] data, input int exp_len);
      int cnt;
      check_eq({tag, ".phase"}, 32'(phase), 32'(ph));
      check_eq({tag, ".starts"}, 32'({init_start, ksa_start, prga_start}), 32'(starts));
      check_eq({tag, ".addr"}, 32'(mem_address), 32'(addr));
      check_eq({tag, ".data"}, 32'(mem_data), 32'(data));
      check_eq({tag, ".we"}, 32'(mem_we), 32'd1);
      check_eq({tag, ".busy"}, 32'(busy), 32'd1);
      cnt = 0;
      while (phase === ph && cnt < 200) begin
         cnt++;
         step();
      end
      check_eq({tag, ".len"}, 32'(cnt), 32'(exp_len));
   endtask

   task automatic gap_check(input string tag);
      check_eq({tag, ".phase"}, 32'(phase), 32'd0);
      check_eq({tag, ".we"}, 32'(mem_we), 32'd0);
      check_eq({tag, ".addr"}, 32'(mem_address), 32'd0);
      check_eq({tag, ".data"}, 32'(mem_data), 32'd0);
      check_eq({tag, ".starts"}, 32'({init_start, ksa_start, prga_start}), 32'd0);
      check_eq({tag, ".busy"}, 32'(busy), 32'd1);
      step();
   endtask

   task automatic idle_check(input string tag);
      check_eq({tag, ".done"}, 32'(done), 32'd0);
      check_eq({tag, ".busy"}, 32'(busy), 32'd0);
      check_eq({tag, ".terr"}, 32'(timeout_error), 32'd0);
      check_eq({tag, ".phase"}, 32'(phase), 32'd0);
      check_eq({tag, ".we"}, 32'(mem_we), 32'd0);
      check_eq({tag, ".addr"}, 32'(mem_address), 32'd0);
      check_eq({tag, ".starts"}, 32'({init_start, ksa_start, prga_start}), 32'd0);
   endtask

   task automatic done_check(input string tag);
      check_eq({tag, ".done"}, 32'(done), 32'd1);
      check_eq({tag, ".busy"}, 32'(busy), 32'd0);
      check_eq({tag, ".we"}, 32'(mem_we), 32'd0);
      check_eq({tag, ".addr"}, 32'(mem_address), 32'd0);
      check_eq({tag, ".starts"}, 32'({init_start, ksa_start, prga_start}), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      step();
      step();
      reset = 1'b0;
      idle_check("reset");
      step();
      idle_check("idle");

      // nominal run, start held high throughout
      start = 1'b1;
      step();
      phase_run("nom_init", 2'd1, 3'b100, 8'h11, 8'hA1, 10);
      gap_check("nom_gap1");
      phase_run("nom_ksa", 2'd2, 3'b010, 8'h22, 8'hB2, 12);
      gap_check("nom_gap2");
      phase_run("nom_prga", 2'd3, 3'b001, 8'h33, 8'hC3, 5);
      done_check("nom_done");
      repeat (3) step();
      done_check("nom_done_hold");
      start = 1'b0;
      step();
      idle_check("nom_release");

      // stray finished pulses during INIT, start dropped during KSA
      start = 1'b1;
      step();
      step();
      prga_fin_force = 1'b1;
      ksa_fin_force  = 1'b1;
      step();
      prga_fin_force = 1'b0;
      ksa_fin_force  = 1'b0;
      check_eq("stray.phase", 32'(phase), 32'd1);
      n = 0;
      while (phase === 2'd1 && n < 200) begin
         n++;
         step();
      end
      check_eq("stray.init_len", 32'(n), 32'd8);
      gap_check("stray_gap1");
      check_eq("drop.phase", 32'(phase), 32'd2);
      repeat (3) step();
      start = 1'b0;
      n = 0;
      while (phase === 2'd2 && n < 200) begin
         n++;
         step();
      end
      check_eq("drop.ksa_len", 32'(n), 32'd9);
      gap_check("drop_gap2");
      phase_run("drop_prga", 2'd3, 3'b001, 8'h33, 8'hC3, 5);
      done_check("drop_done");
      step();
      idle_check("drop_idle");
      step();
      idle_check("drop_no_restart");

      // watchdog expiry in KSA
      ksa_lat = 0;
      start = 1'b1;
      step();
      phase_run("wd_init", 2'd1, 3'b100, 8'h11, 8'hA1, 10);
      gap_check("wd_gap1");
      phase_run("wd_ksa", 2'd2, 3'b010, 8'h22, 8'hB2, 16);
      check_eq("wd.terr", 32'(timeout_error), 32'd1);
      check_eq("wd.starts", 32'({init_start, ksa_start, prga_start}), 32'd0);
      check_eq("wd.we", 32'(mem_we), 32'd0);
      check_eq("wd.busy", 32'(busy), 32'd0);
      check_eq("wd.done", 32'(done), 32'd0);
      repeat (2) step();
      check_eq("wd.hold", 32'(timeout_error), 32'd1);
      start = 1'b0;
      step();
      idle_check("wd_release");

      // finished on the last watchdog cycle wins
      ksa_lat = 16;
      start = 1'b1;
      step();
      phase_run("edge_init", 2'd1, 3'b100, 8'h11, 8'hA1, 10);
      gap_check("edge_gap1");
      phase_run("edge_ksa", 2'd2, 3'b010, 8'h22, 8'hB2, 16);
      check_eq("edge.terr", 32'(timeout_error), 32'd0);
      gap_check("edge_gap2");
      phase_run("edge_prga", 2'd3, 3'b001, 8'h33, 8'hC3, 5);
      done_check("edge_done");
      start = 1'b0;
      step();
      idle_check("edge_idle");

      // synchronous reset in KSA cycle 5, then a clean full run
      ksa_lat = 12;
      start = 1'b1;
      step();
      phase_run("rst_init", 2'd1, 3'b100, 8'h11, 8'hA1, 10);
      gap_check("rst_gap1");
      check_eq("rst.in_ksa", 32'(phase), 32'd2);
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle_check("rst_mid");
      step();
      phase_run("rerun_init", 2'd1, 3'b100, 8'h11, 8'hA1, 10);
      gap_check("rerun_gap1");
      phase_run("rerun_ksa", 2'd2, 3'b010, 8'h22, 8'hB2, 12);
      gap_check("rerun_gap2");
      phase_run("rerun_prga", 2'd3, 3'b001, 8'h33, 8'hC3, 5);
      done_check("rerun_done");
      start = 1'b0;
      step();
      idle_check("rerun_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
